// File: rtl/cv32e40p_clk_gate_pkg.sv
// Shared types and constants for the cv32e40p clock-gate enable sequencer.
// The optional statistics counters use the widths defined here.
package cv32e40p_clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_GATED,
    CG_WAKE,
    CG_RUN,
    CG_IDLE
  } cg_state_e;

  localparam int unsigned GATED_CNT_W = 32;
  localparam int unsigned WAKE_CNT_W  = 16;

endpackage

// File: rtl/cv32e40p_clk_gate_sat_cnt.sv
// Saturating up-counter. It counts inc_i pulses and sticks at all-ones.
module cv32e40p_clk_gate_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Enable sequencer for a shared clock gate: wake, settle, grant, idle hold-off, re-gate.
// Optional macro CV32E40P_CLK_GATE_STATS_EN adds gated-cycle and wake-event counters.
module cv32e40p_clock_gate_ctrl
  import cv32e40p_clk_gate_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned HOLDOFF     = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               busy_i,
  input  logic               test_en_i,
  output logic               clk_en_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               sleeping_o
`ifdef CV32E40P_CLK_GATE_STATS_EN
  ,
  output logic [GATED_CNT_W-1:0] gated_cycles_o,
  output logic [WAKE_CNT_W-1:0]  wake_count_o
`endif
);

  localparam int unsigned MAX_CNT = (WAKE_CYCLES > HOLDOFF) ? WAKE_CYCLES : HOLDOFF;
  localparam int unsigned CW      = (MAX_CNT == 0) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CW'(WAKE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

  cg_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          activity;

  assign activity = (|req_i) | busy_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CG_GATED;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_GATED: begin
        if (activity) begin
          if (WAKE_CYCLES == 0) begin
            state_d = CG_RUN;
          end else begin
            state_d = CG_WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
      end
      CG_WAKE: begin
        // Dropped requests do not abort the wake; the domain settles regardless.
        if (cnt_q == '0) begin
          state_d = CG_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CG_RUN: begin
        if (!activity) begin
          if (HOLDOFF == 0) begin
            state_d = CG_GATED;
          end else begin
            state_d = CG_IDLE;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      CG_IDLE: begin
        if (activity) begin
          state_d = CG_RUN;
        end else if (cnt_q == '0) begin
          state_d = CG_GATED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = CG_GATED;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d != CG_GATED);
  end

  assign clk_en_o   = en_q | test_en_i;
  assign ack_o      = (state_q == CG_RUN) ? req_i : '0;
  assign sleeping_o = (state_q == CG_GATED);

`ifdef CV32E40P_CLK_GATE_STATS_EN
  logic wake_event;
  assign wake_event = (state_q == CG_GATED) && (state_d != CG_GATED);

  cv32e40p_clk_gate_sat_cnt #(.WIDTH(GATED_CNT_W)) u_gated_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (!en_q),
    .cnt_o  (gated_cycles_o)
  );

  cv32e40p_clk_gate_sat_cnt #(.WIDTH(WAKE_CNT_W)) u_wake_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (wake_event),
    .cnt_o  (wake_count_o)
  );
`endif

endmodule
